dmem_load_align: RTL and testbench
==================================

Name: dmem_load_align

Overview:
Parametrised load-data unit that generalises the existing combinational dmem shift/extend path. It accepts a load request (address, size, sign mode, tag) and issues one or two word reads to the data memory port. When the access crosses a word boundary it merges both beats. It then shifts, sign/zero-extends and returns the result through a valid/ready response channel, sitting between the LSU issue stage and the writeback mux.

Parameters:
XLEN, 32, data word width; 32 or 64.
ADDR_W, 32, byte address width.
TAG_W, 5, destination tag width, carried through unchanged.
MISALIGN_EN, 1, 1 = split word-crossing loads into two reads; 0 = flag them as errors.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of the current load
req_valid  in  1  load request valid
req_ready  out  1  unit can accept a request
req_addr  in  ADDR_W  byte address
req_size  in  2  DMEM_EXT_BYTE/HALF/WORD/DWORD
req_unsign  in  1  1 = zero-extend, 0 = sign-extend
req_tag  in  TAG_W  destination tag
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word-aligned read address
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  XLEN  read data word
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  XLEN  extended result
rsp_tag  out  TAG_W  tag of the result
rsp_err  out  1  misaligned/unsupported access

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset values: state IDLE; req_ready=1; mem_req_valid=0; rsp_valid=0; mem_req_addr, rsp_data, rsp_tag and rsp_err all 0.
- NB=XLEN/8. off=req_addr[log2(NB)-1:0]. bytes=1<<req_size. cross=(off+bytes>NB).
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN.
- IDLE: req_ready=1, and only in IDLE. On req_valid the unit latches addr, size, unsign and tag.
  - If the request is an error, go to RESP with rsp_err=1 and rsp_data=0. Error cases: DWORD with XLEN=32, or cross with MISALIGN_EN=0.
  - Otherwise go to REQ0.
- REQ0/REQ1: mem_req_valid=1. mem_req_addr is the word base (REQ0) or base+NB (REQ1). The +NB wraps modulo 2^ADDR_W. The address is held stable until mem_req_ready, then the state moves to WAIT0/WAIT1.
- WAIT0: on mem_rsp_valid, capture beat0, then go to REQ1 if cross, else RESP. WAIT1: on mem_rsp_valid, capture beat1, then go to RESP.
- mem_rsp_valid outside WAIT0/WAIT1/DRAIN is ignored. At most one memory read is outstanding.
- Merge: {beat1,beat0} >> (off*8), low bytes selected, bits above 8*bytes filled with (~unsign & msb). For WORD with XLEN=64, bits [63:32] are extended. Non-crossing unaligned offsets need a single beat.
- RESP: rsp_valid=1. rsp_data, rsp_tag and rsp_err are held stable until rsp_ready, then the state returns to IDLE. No bypass: the next request is accepted the cycle after the response handshake.
- Latency: aligned load with mem_req_ready=1 and a one-cycle memory gives mem_req_valid at T+1 (T = acceptance edge) and rsp_valid at T+3. A split load gives rsp_valid at T+5. An error load gives rsp_valid at T+1.
- flush:
  - From REQ0/REQ1/RESP, go to IDLE at the next edge with no rsp_valid. A request already granted in that cycle counts as outstanding, so the state goes to DRAIN instead.
  - From WAIT0/WAIT1, go to DRAIN. DRAIN discards the next mem_rsp_valid, then goes to IDLE.
  - flush in IDLE blocks acceptance that cycle.
- Reset asserted mid-operation returns everything to the reset values immediately. Any outstanding memory response is then the memory's responsibility.

Decomposition:
- CtrlCode.vh: add DMEM_EXT_DWORD in the unused 2-bit size code; existing BYTE/HALF/WORD codes are unchanged. State encodings stay local parameters.
- Sub-module dmem_merge_ext: combinational, takes a 2*XLEN concatenation plus off/size/unsign and produces XLEN extended data.

Test Plan:
- XLEN=32, addr 0x1002, HALF signed, mem 0x80011234 → one read at 0x1000; rsp_data 0xFFFF8001, rsp_err=0.
- addr 0x1003, WORD unsigned, beats 0xAABBCCDD@0x1000 and 0x11223344@0x1004 → two reads; rsp_data 0x223344AA; rsp_valid at T+5.
- MISALIGN_EN=0, same addr 0x1003 WORD → mem_req_valid never 1; rsp_valid at T+1, rsp_err=1, rsp_data=0, tag echoed.
- mem_req_ready low 3 cycles, then rsp_ready low 2 cycles → mem_req_addr stable; rsp_data/tag stable; req_ready=0 throughout, then 1 after the handshake.
- XLEN=64, addr 0x2006, WORD signed, beats 0x0000_0000_8000_0000_0000 pattern with bytes [0x2006..0x2009]=00 00 00 80 → rsp_data 0xFFFFFFFF80000000. Same with XLEN=32 and DWORD → rsp_err=1.
- flush during WAIT1, then mem_rsp_valid → no rsp_valid, req_ready=1 the cycle after the drained response; rst_n low in WAIT0 → all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/dmem_load_align_pkg.sv
// Shared size codes, FSM states and helpers for the load-data unit.
// Size codes match the original CtrlCode encoding; DWORD takes the spare code.
package dmem_load_align_pkg;

   localparam logic [1:0] DMEM_EXT_BYTE  = 2'd0;
   localparam logic [1:0] DMEM_EXT_HALF  = 2'd1;
   localparam logic [1:0] DMEM_EXT_WORD  = 2'd2;
   localparam logic [1:0] DMEM_EXT_DWORD = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5,
      ST_DRAIN = 3'd6
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/dmem_merge_ext.sv
// Shifts a two-beat window down to the addressed byte and
// sign/zero-extends the selected width to a full word.
module dmem_merge_ext
   import dmem_load_align_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [2*XLEN-1:0] cat_i,
   input  logic [OFF_W-1:0]  off_i,
   input  logic [1:0]        size_i,
   input  logic              unsign_i,
   output logic [XLEN-1:0]   data_o
);

   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic            msb;
   logic            fill;

   always_comb begin
      sh   = XLEN'(cat_i >> {off_i, 3'b000});
      mask = '1;
      msb  = sh[XLEN-1];
      unique case (size_i)
         DMEM_EXT_BYTE: begin
            mask = XLEN'(8'hFF);
            msb  = sh[7];
         end
         DMEM_EXT_HALF: begin
            mask = XLEN'(16'hFFFF);
            msb  = sh[15];
         end
         DMEM_EXT_WORD: begin
            mask = XLEN'(32'hFFFF_FFFF);
            msb  = sh[31];
         end
         DMEM_EXT_DWORD: begin
            mask = '1;
            msb  = sh[XLEN-1];
         end
      endcase
      fill   = ~unsign_i & msb;
      data_o = (sh & mask) | (~mask & {XLEN{fill}});
   end

endmodule

// File: rtl/dmem_load_align.sv
// Load-data unit: issues one or two word reads per load, merges
// word-crossing beats, extends the result and returns it on valid/ready.
module dmem_load_align
   import dmem_load_align_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TAG_W       = 5,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsign,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   state_e            state_q, state_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              unsign_q, unsign_d;
   logic              cross_q, cross_d;
   logic [XLEN-1:0]   beat0_q, beat0_d;

   logic              req_ready_q, req_ready_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic              rsp_err_q, rsp_err_d;

   logic [OFF_W-1:0]  req_off;
   logic [4:0]        req_end;
   logic              req_cross;
   logic              req_err;
   logic [ADDR_W-1:0] req_base;
   logic [2*XLEN-1:0] merge_cat;
   logic [XLEN-1:0]   merge_data;

   always_comb begin
      req_off   = req_addr[OFF_W-1:0];
      req_end   = 5'(req_off) + 5'(size_bytes(req_size));
      req_cross = req_end > 5'(NB);
      req_err   = ((req_size == DMEM_EXT_DWORD) && (XLEN == 32)) ||
                  (req_cross && !MISALIGN_EN);
      req_base  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   end

   // Second beat only exists in WAIT1; a single beat sits in the low half.
   always_comb begin
      if (state_q == ST_WAIT1) begin
         merge_cat = {mem_rsp_data, beat0_q};
      end else begin
         merge_cat = {{XLEN{1'b0}}, mem_rsp_data};
      end
   end

   dmem_merge_ext #(
      .XLEN (XLEN)
   ) u_merge (
      .cat_i    (merge_cat),
      .off_i    (off_q),
      .size_i   (size_q),
      .unsign_i (unsign_q),
      .data_o   (merge_data)
   );

   always_comb begin
      state_d        = state_q;
      off_d          = off_q;
      size_d         = size_q;
      unsign_d       = unsign_q;
      cross_d        = cross_q;
      beat0_d        = beat0_q;
      mem_req_addr_d = mem_req_addr_q;
      rsp_data_d     = rsp_data_q;
      rsp_tag_d      = rsp_tag_q;
      rsp_err_d      = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               off_d      = req_off;
               size_d     = req_size;
               unsign_d   = req_unsign;
               cross_d    = req_cross;
               rsp_tag_d  = req_tag;
               rsp_err_d  = req_err;
               rsp_data_d = '0;
               if (req_err) begin
                  state_d = ST_RESP;
               end else begin
                  state_d        = ST_REQ0;
                  mem_req_addr_d = req_base;
               end
            end
         end
         ST_REQ0: begin
            if (mem_req_ready) begin
               state_d = flush ? ST_DRAIN : ST_WAIT0;
            end else if (flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT0: begin
            if (mem_rsp_valid) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else if (cross_q) begin
                  state_d        = ST_REQ1;
                  beat0_d        = mem_rsp_data;
                  mem_req_addr_d = mem_req_addr_q + ADDR_W'(NB);
               end else begin
                  state_d    = ST_RESP;
                  rsp_data_d = merge_data;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_REQ1: begin
            if (mem_req_ready) begin
               state_d = flush ? ST_DRAIN : ST_WAIT1;
            end else if (flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT1: begin
            if (mem_rsp_valid) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_RESP;
                  rsp_data_d = merge_data;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_RESP: begin
            if (flush || rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_rsp_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d     = (state_d == ST_IDLE);
      mem_req_valid_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
      rsp_valid_d     = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         off_q           <= '0;
         size_q          <= '0;
         unsign_q        <= 1'b0;
         cross_q         <= 1'b0;
         beat0_q         <= '0;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_data_q      <= '0;
         rsp_tag_q       <= '0;
         rsp_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         off_q           <= off_d;
         size_q          <= size_d;
         unsign_q        <= unsign_d;
         cross_q         <= cross_d;
         beat0_q         <= beat0_d;
         req_ready_q     <= req_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_data_q      <= rsp_data_d;
         rsp_tag_q       <= rsp_tag_d;
         rsp_err_q       <= rsp_err_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_tag       = rsp_tag_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_dmem_load_align.sv
// Bench for dmem_load_align: 32-bit split-capable, 32-bit no-split and
// 64-bit instances, with a memory model and response scoreboard.
module tb_dmem_load_align;
   import dmem_load_align_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsign = 1'b0;
   logic [4:0]  req_tag = '0;
   logic        mem_req_ready = 1'b1;
   logic        rsp_ready = 1'b1;

   logic        req_valid_a = 1'b0, req_ready_a;
   logic        mem_req_valid_a;
   logic [31:0] mem_req_addr_a;
   logic        mem_rsp_valid_a = 1'b0;
   logic [31:0] mem_rsp_data_a = '0;
   logic        rsp_valid_a, rsp_err_a;
   logic [31:0] rsp_data_a;
   logic [4:0]  rsp_tag_a;

   logic        req_valid_b = 1'b0, req_ready_b;
   logic        mem_req_valid_b;
   logic [31:0] mem_req_addr_b;
   logic        mem_rsp_valid_b = 1'b0;
   logic [31:0] mem_rsp_data_b = '0;
   logic        rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_data_b;
   logic [4:0]  rsp_tag_b;

   logic        req_valid_c = 1'b0, req_ready_c;
   logic        mem_req_valid_c;
   logic [31:0] mem_req_addr_c;
   logic        mem_rsp_valid_c = 1'b0;
   logic [63:0] mem_rsp_data_c = '0;
   logic        rsp_valid_c, rsp_err_c;
   logic [63:0] rsp_data_c;
   logic [4:0]  rsp_tag_c;

   dmem_load_align #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_addr(req_addr), .req_size(req_size),
      .req_unsign(req_unsign), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid_a), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr_a),
      .mem_rsp_valid(mem_rsp_valid_a), .mem_rsp_data(mem_rsp_data_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_a), .rsp_tag(rsp_tag_a), .rsp_err(rsp_err_a)
   );

   dmem_load_align #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_addr(req_addr), .req_size(req_size),
      .req_unsign(req_unsign), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr_b),
      .mem_rsp_valid(mem_rsp_valid_b), .mem_rsp_data(mem_rsp_data_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_b), .rsp_tag(rsp_tag_b), .rsp_err(rsp_err_b)
   );

   dmem_load_align #(.XLEN(64), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid_c), .req_ready(req_ready_c),
      .req_addr(req_addr), .req_size(req_size),
      .req_unsign(req_unsign), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid_c), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr_c),
      .mem_rsp_valid(mem_rsp_valid_c), .mem_rsp_data(mem_rsp_data_c),
      .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_c), .rsp_tag(rsp_tag_c), .rsp_err(rsp_err_c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [4:0]  tag;
      logic [31:0] b0;
      logic [31:0] b1;
      int          nb;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      logic        err;
      int          t_acc;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] cur_base = '0, cur_b0 = '0, cur_b1 = '0;
   int          mem_delay = 0;
   bit          rsp_seen = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        vecs[11];

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   task automatic issue_a(input vec_t v, input bit push_exp, input int lat);
      int k;
      logic [31:0] base;
      k = 0;
      while (!req_ready_a && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("issue_ready", 64'(req_ready_a), 64'(1));
      base     = {v.addr[31:2], 2'b00};
      cur_base = base;
      cur_b0   = v.b0;
      cur_b1   = v.b1;
      if (v.nb > 0) addr_q.push_back(base);
      if (v.nb > 1) addr_q.push_back(base + 32'd4);
      req_addr    = v.addr;
      req_size    = v.size;
      req_unsign  = v.uns;
      req_tag     = v.tag;
      req_valid_a = 1'b1;
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      if (push_exp) exp_q.push_back('{v.exp, v.tag, v.err, cyc, lat});
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || addr_q.size() != 0 || !req_ready_a) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("idle_timeout", 64'(k < 100), 64'(1));
   endtask

   task automatic run_c(input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [4:0] tag,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input int nb, input logic [63:0] exp);
      int beats;
      bit done;
      logic [31:0] base;
      beats = 0;
      done  = 1'b0;
      base  = {addr[31:3], 3'b000};
      req_addr    = addr;
      req_size    = sz;
      req_unsign  = uns;
      req_tag     = tag;
      req_valid_c = 1'b1;
      @(posedge clk); #1;
      req_valid_c = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         if (rsp_valid_c) begin
            chk("c_data", rsp_data_c, exp);
            chk("c_tag", 64'(rsp_tag_c), 64'(tag));
            chk("c_err", 64'(rsp_err_c), 64'(0));
            done = 1'b1;
         end else if (mem_req_valid_c && mem_req_ready) begin
            chk("c_mem_addr", 64'(mem_req_addr_c), 64'(base + 32'(beats * 8)));
            @(posedge clk); #1;
            mem_rsp_valid_c = 1'b1;
            mem_rsp_data_c  = (beats == 0) ? b0 : b1;
            beats++;
            @(posedge clk); #1;
            mem_rsp_valid_c = 1'b0;
         end
      end
      chk("c_done", 64'(done), 64'(1));
      chk("c_beats", 64'(beats), 64'(nb));
      @(posedge clk); #1;
   endtask

   initial begin
      vecs = '{
         '{32'h0000_1002, DMEM_EXT_HALF,  1'b0, 5'd1,  32'h8001_1234, 32'h0,         1, 32'hFFFF_8001, 1'b0},
         '{32'h0000_1003, DMEM_EXT_WORD,  1'b1, 5'd2,  32'hAABB_CCDD, 32'h1122_3344, 2, 32'h2233_44AA, 1'b0},
         '{32'h0000_1001, DMEM_EXT_BYTE,  1'b0, 5'd3,  32'h1234_F600, 32'h0,         1, 32'hFFFF_FFF6, 1'b0},
         '{32'h0000_1001, DMEM_EXT_BYTE,  1'b1, 5'd4,  32'h1234_F600, 32'h0,         1, 32'h0000_00F6, 1'b0},
         '{32'h0000_2000, DMEM_EXT_WORD,  1'b0, 5'd5,  32'hDEAD_BEEF, 32'h0,         1, 32'hDEAD_BEEF, 1'b0},
         '{32'h0000_2003, DMEM_EXT_HALF,  1'b1, 5'd6,  32'h80FF_FFFF, 32'h0000_00FE, 2, 32'h0000_FE80, 1'b0},
         '{32'h0000_2003, DMEM_EXT_HALF,  1'b0, 5'd7,  32'h80FF_FFFF, 32'h0000_00FE, 2, 32'hFFFF_FE80, 1'b0},
         '{32'h0000_2001, DMEM_EXT_HALF,  1'b0, 5'd8,  32'h007F_FF00, 32'h0,         1, 32'h0000_7FFF, 1'b0},
         '{32'hFFFF_FFFE, DMEM_EXT_WORD,  1'b1, 5'd9,  32'h5566_7788, 32'h99AA_BBCC, 2, 32'hBBCC_5566, 1'b0},
         '{32'h0000_3000, DMEM_EXT_DWORD, 1'b0, 5'd10, 32'h0,         32'h0,         0, 32'h0,         1'b1},
         '{32'h0000_1000, DMEM_EXT_BYTE,  1'b0, 5'd11, 32'h0000_007F, 32'h0,         1, 32'h0000_007F, 1'b0}
      };

      fork
         begin : watchdog
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
         begin : mem_model_a
            logic [31:0] ma;
            forever begin
               @(negedge clk);
               if (rst_n && mem_req_valid_a && mem_req_ready) begin
                  ma = mem_req_addr_a;
                  if (addr_q.size() == 0) chk("unexpected_mem_req", 64'(mem_req_valid_a), 64'(0));
                  else chk("mem_req_addr", 64'(ma), 64'(addr_q.pop_front()));
                  @(posedge clk);
                  repeat (mem_delay) @(posedge clk);
                  #1;
                  mem_rsp_valid_a = 1'b1;
                  mem_rsp_data_a  = (ma == cur_base) ? cur_b0 : cur_b1;
                  @(posedge clk); #1;
                  mem_rsp_valid_a = 1'b0;
               end
            end
         end
         begin : rsp_monitor_a
            exp_t e;
            forever begin
               @(negedge clk);
               if (rst_n && rsp_valid_a) begin
                  if (exp_q.size() == 0) begin
                     chk("spurious_rsp", 64'(rsp_valid_a), 64'(0));
                  end else begin
                     e = exp_q[0];
                     if (!rsp_seen) begin
                        rsp_seen = 1'b1;
                        if (e.lat != 0) chk("latency", 64'(cyc - e.t_acc + 1), 64'(e.lat));
                     end
                     if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        chk("rsp_data", 64'(rsp_data_a), 64'(e.data));
                        chk("rsp_tag", 64'(rsp_tag_a), 64'(e.tag));
                        chk("rsp_err", 64'(rsp_err_a), 64'(e.err));
                        rsp_seen = 1'b0;
                     end
                  end
               end
            end
         end
      join_none

      // reset values
      #12;
      chk("rst_req_ready", 64'(req_ready_a), 64'(1));
      chk("rst_mem_req_valid", 64'(mem_req_valid_a), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_a), 64'(0));
      chk("rst_mem_req_addr", 64'(mem_req_addr_a), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data_a), 64'(0));
      chk("rst_c_req_ready", 64'(req_ready_c), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // table of single loads with full-rate memory and consumer
      for (int i = 0; i < 11; i++) begin
         issue_a(vecs[i], 1'b1, 2 * vecs[i].nb + 1);
         wait_idle();
      end

      // memory stall then consumer stall
      mem_req_ready = 1'b0;
      rsp_ready     = 1'b0;
      issue_a('{32'h0000_4000, DMEM_EXT_WORD, 1'b0, 5'd21, 32'h0102_0304, 32'h0, 1,
                32'h0102_0304, 1'b0}, 1'b1, 0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_mem_valid", 64'(mem_req_valid_a), 64'(1));
         chk("stall_mem_addr", 64'(mem_req_addr_a), 64'h4000);
         chk("stall_req_ready", 64'(req_ready_a), 64'(0));
      end
      @(posedge clk); #1;
      mem_req_ready = 1'b1;
      begin
         int k;
         k = 0;
         while (!rsp_valid_a && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("stall_rsp_seen", 64'(rsp_valid_a), 64'(1));
      end
      repeat (2) begin
         @(negedge clk);
         chk("hold_rsp_valid", 64'(rsp_valid_a), 64'(1));
         chk("hold_rsp_data", 64'(rsp_data_a), 64'h0102_0304);
         chk("hold_rsp_tag", 64'(rsp_tag_a), 64'(21));
         chk("hold_req_ready", 64'(req_ready_a), 64'(0));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_req_ready_before", 64'(req_ready_a), 64'(0));
      @(posedge clk); #1;
      chk("hs_req_ready_after", 64'(req_ready_a), 64'(1));
      wait_idle();

      // flush while waiting for the second beat
      mem_delay = 2;
      issue_a(vecs[1], 1'b0, 0);
      begin
         int k;
         k = 0;
         while (!(mem_req_valid_a && mem_req_addr_a == 32'h0000_1004) && k < 30) begin
            @(negedge clk);
            k++;
         end
         chk("flush_reach_req1", 64'(mem_req_valid_a), 64'(1));
      end
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      begin
         int k;
         k = 0;
         while (!mem_rsp_valid_a && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("drain_rsp_seen", 64'(mem_rsp_valid_a), 64'(1));
      end
      chk("drain_req_ready", 64'(req_ready_a), 64'(0));
      chk("drain_rsp_valid", 64'(rsp_valid_a), 64'(0));
      @(posedge clk); #1;
      chk("drain_done_ready", 64'(req_ready_a), 64'(1));
      repeat (4) @(posedge clk);
      #1;
      chk("flush_no_rsp", 64'(exp_q.size()), 64'(0));

      // asynchronous reset while waiting for the first beat
      mem_delay = 3;
      issue_a('{32'h0000_1000, DMEM_EXT_BYTE, 1'b0, 5'd17, 32'h0, 32'h0, 1,
                32'h0, 1'b0}, 1'b0, 0);
      begin
         int k;
         k = 0;
         while (!mem_req_valid_a && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("rst_test_req0", 64'(mem_req_valid_a), 64'(1));
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_ready", 64'(req_ready_a), 64'(1));
      chk("async_mem_valid", 64'(mem_req_valid_a), 64'(0));
      chk("async_mem_addr", 64'(mem_req_addr_a), 64'(0));
      chk("async_rsp_valid", 64'(rsp_valid_a), 64'(0));
      chk("async_rsp_data", 64'(rsp_data_a), 64'(0));
      chk("async_rsp_tag", 64'(rsp_tag_a), 64'(0));
      chk("async_rsp_err", 64'(rsp_err_a), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      mem_delay = 0;

      // split disabled: crossing load is an error with no memory traffic
      req_addr    = 32'h0000_1003;
      req_size    = DMEM_EXT_WORD;
      req_unsign  = 1'b1;
      req_tag     = 5'd5;
      req_valid_b = 1'b1;
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      @(negedge clk);
      chk("b_rsp_valid_t1", 64'(rsp_valid_b), 64'(1));
      chk("b_rsp_err", 64'(rsp_err_b), 64'(1));
      chk("b_rsp_data", 64'(rsp_data_b), 64'(0));
      chk("b_rsp_tag", 64'(rsp_tag_b), 64'(5));
      chk("b_no_mem_req", 64'(mem_req_valid_b), 64'(0));
      @(negedge clk);
      chk("b_rsp_done", 64'(rsp_valid_b), 64'(0));
      chk("b_no_mem_req2", 64'(mem_req_valid_b), 64'(0));
      chk("b_ready_again", 64'(req_ready_b), 64'(1));
      @(posedge clk); #1;

      // 64-bit datapath
      run_c(32'h0000_2006, DMEM_EXT_WORD, 1'b0, 5'd12, 64'h0000_1122_3344_5566,
            64'h7766_5544_3322_8000, 2, 64'hFFFF_FFFF_8000_0000);
      run_c(32'h0000_2004, DMEM_EXT_WORD, 1'b1, 5'd13, 64'h8765_4321_0000_0000,
            64'h0, 1, 64'h0000_0000_8765_4321);
      run_c(32'h0000_2000, DMEM_EXT_DWORD, 1'b0, 5'd14, 64'h8877_6655_4433_2211,
            64'h0, 1, 64'h8877_6655_4433_2211);
      run_c(32'h0000_2007, DMEM_EXT_HALF, 1'b0, 5'd15, 64'h8877_6655_4433_2211,
            64'h0000_0000_0000_0099, 2, 64'hFFFF_FFFF_FFFF_9988);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
